// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two requesters share one register-file write port.
// Round-robin grant, one-cycle registered write, saturating conflict counter.
module wb_port_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_stall,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_MemtoReg,
    input  logic [DATA_W-1:0] req0_read_data,
    input  logic [DATA_W-1:0] req0_address,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_MemtoReg,
    input  logic [DATA_W-1:0] req1_read_data,
    input  logic [DATA_W-1:0] req1_address,
    input  logic [ADDR_W-1:0] req1_rd,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              r_prio;
    logic              w_open;
    logic              w_both;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_val0;
    logic [DATA_W-1:0] w_val1;
    logic [DATA_W-1:0] w_val;

    // Grant is suppressed while in reset so nothing is accepted and then lost.
    assign w_open = reset_n & ~wb_stall;
    assign w_both = req0_valid & req1_valid;
    assign w_gnt0 = w_open & req0_valid & (~req1_valid | ~r_prio);
    assign w_gnt1 = w_open & req1_valid & (~req0_valid | r_prio);
    assign w_xfer = w_gnt0 | w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_val0 = req0_MemtoReg ? req0_read_data : req0_address;
    assign w_val1 = req1_MemtoReg ? req1_read_data : req1_address;
    assign w_val  = w_gnt1 ? w_val1 : w_val0;
    assign w_rd   = w_gnt1 ? req1_rd : req0_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio        <= 1'b0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            conflict_cnt  <= '0;
        end else begin
            RegWrite <= w_xfer && (w_rd != ADDR_W'(ZERO_REG));
            if (w_xfer) begin
                WriteRegister <= w_rd;
                WriteData     <= w_val;
                r_prio        <= w_gnt0;
            end
            if (w_both && !wb_stall && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed plan steps plus random
// traffic compared against a behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        wb_stall;
    logic        tv  [2];
    logic        tms [2];
    logic [63:0] trd [2];
    logic [63:0] tad [2];
    logic [4:0]  tri_ [2];
    logic        req0_ready;
    logic        req1_ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [7:0]  conflict_cnt;

    int n_tests;
    int n_fail;

    int          m_prio;
    int          m_cnt;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [63:0] m_wd;
    int          grants[$];

    wb_port_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb_stall       (wb_stall),
        .req0_valid     (tv[0]),
        .req0_ready     (req0_ready),
        .req0_MemtoReg  (tms[0]),
        .req0_read_data (trd[0]),
        .req0_address   (tad[0]),
        .req0_rd        (tri_[0]),
        .req1_valid     (tv[1]),
        .req1_ready     (req1_ready),
        .req1_MemtoReg  (tms[1]),
        .req1_read_data (trd[1]),
        .req1_address   (tad[1]),
        .req1_rd        (tri_[1]),
        .RegWrite       (RegWrite),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .conflict_cnt   (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0;
        m_cnt  = 0;
        m_we   = 1'b0;
        m_wr   = '0;
        m_wd   = '0;
    endtask

    task automatic set_req(int k, logic v, logic ms, logic [63:0] rdat,
                           logic [63:0] addr, logic [4:0] rd);
        tv[k]   = v;
        tms[k]  = ms;
        trd[k]  = rdat;
        tad[k]  = addr;
        tri_[k] = rd;
    endtask

    function automatic int winner();
        if (wb_stall) return -1;
        if (tv[0] && tv[1]) return m_prio;
        if (tv[0]) return 0;
        if (tv[1]) return 1;
        return -1;
    endfunction

    // Entered at posedge+1; checks grants mid-cycle, then registered outputs.
    task automatic step(string tag);
        int  w;
        bit  dual;
        @(negedge clk);
        w    = winner();
        dual = tv[0] && tv[1] && !wb_stall;
        chk({tag, "_rdy0"}, {63'd0, req0_ready}, {63'd0, w == 0});
        chk({tag, "_rdy1"}, {63'd0, req1_ready}, {63'd0, w == 1});
        grants.push_back(w);
        @(posedge clk);
        #1;
        if (w >= 0) begin
            m_wr   = tri_[w];
            m_wd   = tms[w] ? trd[w] : tad[w];
            m_we   = (tri_[w] != 5'd31);
            m_prio = 1 - w;
        end else begin
            m_we = 1'b0;
        end
        if (dual && m_cnt < 255) m_cnt++;
        chk({tag, "_we"},  {63'd0, RegWrite}, {63'd0, m_we});
        chk({tag, "_wr"},  {59'd0, WriteRegister}, {59'd0, m_wr});
        chk({tag, "_wd"},  WriteData, m_wd);
        chk({tag, "_cnt"}, {56'd0, conflict_cnt}, 64'(m_cnt));
    endtask

    task automatic quick_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        wb_stall = 1'b0;
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        model_reset();
        #12;
        chk("rst_we",  {63'd0, RegWrite}, 64'd0);
        chk("rst_wr",  {59'd0, WriteRegister}, 64'd0);
        chk("rst_wd",  WriteData, 64'd0);
        chk("rst_cnt", {56'd0, conflict_cnt}, 64'd0);
        set_req(0, 1, 1, 64'hAAAA, 64'h1234, 5'd3);
        #1;
        chk("rst_nogrant", {63'd0, req0_ready}, 64'd0);
        set_req(0, 0, 0, '0, '0, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single write from req0
        set_req(0, 1, 1, 64'hAAAA, 64'h1234, 5'd3);
        step("single");
        chk("single_we", {63'd0, RegWrite}, 64'd1);
        chk("single_wr", {59'd0, WriteRegister}, 64'd3);
        chk("single_wd", WriteData, 64'hAAAA);
        set_req(0, 0, 0, '0, '0, '0);
        step("idle");
        chk("idle_we", {63'd0, RegWrite}, 64'd0);
        chk("idle_wd", WriteData, 64'hAAAA);

        // alternating dual requests from a fresh priority
        quick_reset();
        set_req(0, 1, 0, 64'hDEAD, 64'h10, 5'd1);
        set_req(1, 1, 1, 64'h20, 64'hBEEF, 5'd2);
        grants.delete();
        for (int i = 0; i < 4; i++) begin
            step("dual");
            chk("dual_wd", WriteData, (i % 2 == 0) ? 64'h10 : 64'h20);
        end
        for (int i = 0; i < 4; i++)
            chk("dual_order", 64'(grants[i]), 64'(i % 2));
        chk("dual_cnt", {56'd0, conflict_cnt}, 64'd4);

        // write to the zero register is accepted but not committed
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 1, 0, 64'h5, 64'h77, 5'd31);
        step("zero");
        chk("zero_we", {63'd0, RegWrite}, 64'd0);
        set_req(1, 0, 0, '0, '0, '0);
        step("zero_idle");

        // stall holds everything, then req0 wins on release
        set_req(0, 1, 0, '0, 64'h111, 5'd4);
        set_req(1, 1, 0, '0, 64'h222, 5'd5);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_cnt", {56'd0, conflict_cnt}, 64'd4);
        wb_stall = 1'b0;
        grants.delete();
        step("unstall");
        chk("unstall_first", 64'(grants[0]), 64'd0);
        chk("unstall_wd", WriteData, 64'h111);

        // saturation
        for (int i = 0; i < 300; i++) step("sat");
        chk("sat_cnt", {56'd0, conflict_cnt}, 64'd255);

        // random traffic against the model
        quick_reset();
        for (int i = 0; i < 250; i++) begin
            wb_stall = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < 2; k++)
                set_req(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        {$urandom, $urandom}, {$urandom, $urandom},
                        5'($urandom_range(0, 31)));
            step("rnd");
        end

        // asynchronous reset in the middle of back-to-back transfers
        wb_stall = 1'b0;
        set_req(0, 1, 1, 64'hCAFE, 64'h0, 5'd7);
        set_req(1, 1, 0, 64'h0, 64'hF00D, 5'd8);
        step("b2b");
        step("b2b");
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_we",  {63'd0, RegWrite}, 64'd0);
        chk("arst_wr",  {59'd0, WriteRegister}, 64'd0);
        chk("arst_wd",  WriteData, 64'd0);
        chk("arst_cnt", {56'd0, conflict_cnt}, 64'd0);
        chk("arst_rdy", {62'd0, req1_ready, req0_ready}, 64'd0);
        model_reset();
        reset_n = 1'b1;
        grants.delete();
        step("post");
        chk("post_first", 64'(grants[0]), 64'd0);
        chk("post_wd", WriteData, 64'hCAFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 is the main pipeline WB stage; req1 is a multi-cycle unit such as a multiplier or late load.
- Each requester supplies a memory read value, an ALU/address value and a MemtoReg select. The block selects the writeback value, arbitrates round-robin and registers the winning write onto the register-file write port.
- Sits between the MEM/WB boundary and the register file.

Parameters:
- DATA_W, 64, width of writeback data.
- ADDR_W, 5, register index width.
- ZERO_REG, 31, index of the hardwired zero register; writes to it are discarded.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_stall  in  1  register-file write port unavailable this cycle.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_MemtoReg  in  1  1 selects req0_read_data, 0 selects req0_address.
- req0_read_data  in  DATA_W  data memory read value.
- req0_address  in  DATA_W  ALU result / data memory address.
- req0_rd  in  ADDR_W  destination register.
- req1_valid, req1_ready, req1_MemtoReg, req1_read_data, req1_address, req1_rd: same as req0 for requester 1.
- RegWrite  out  1  register-file write enable.
- WriteRegister  out  ADDR_W  register-file write index.
- WriteData  out  DATA_W  register-file write data.
- conflict_cnt  out  CNT_W  count of cycles where both requesters were valid, saturating.

Behaviour:

Reset (reset_n=0, asynchronous, any time including mid-transfer):
- RegWrite=0, WriteRegister=0, WriteData=0, conflict_cnt=0, prio=0 (req0 favoured).
- No grant while reset_n=0.

Grant (combinational, same cycle):
- wb_stall=1: no grant.
- Else, exactly one valid requester: that requester is granted.
- Else, both valid: requester prio is granted.
- reqK_ready = grant to K. A transfer occurs when reqK_valid & reqK_ready.
- A requester keeps valid and its payload stable until ready is seen; the arbiter does not depend on this.

Priority update (clock edge):
- After any transfer by requester K, prio := 1-K.
- With no transfer, prio holds.

Datapath:
- Winner's value = MemtoReg ? read_data : address.
- Latency is one cycle: on the edge ending a transfer cycle, WriteRegister := rd and WriteData := value.
- RegWrite := 1 only if rd != ZERO_REG; otherwise RegWrite := 0, but the transfer still completes (ready asserted, prio updates).

Idle (no transfer, including wb_stall=1):
- RegWrite := 0 on the next edge.
- WriteRegister and WriteData hold their last values.
- RegWrite is therefore a one-cycle pulse per accepted write. Back-to-back transfers give back-to-back pulses.

Conflicts:
- conflict_cnt increments on each edge where req0_valid & req1_valid & !wb_stall.
- Saturates at 2^CNT_W-1 with no wrap.

Boundary conditions:
- Both requesters target the same rd in the same cycle: the winner writes first, the loser the following cycle, so the loser's value is final. Ordering between units is the issuers' responsibility.
- Continuous dual requests alternate grants strictly (0,1,0,1,... from reset). Neither requester waits more than one cycle while unstalled.
- wb_stall asserted while a requester is valid: ready=0 and the payload is untouched. The grant resumes with the unchanged prio on the first unstalled cycle.
- Requester deasserts valid without a grant: no effect.

Test Plan:
- Reset, then req0 alone with rd=3, MemtoReg=1, read_data=0xAAAA, address=0x1234 -> req0_ready=1 that cycle. Next cycle: RegWrite=1, WriteRegister=3, WriteData=0xAAAA. Following idle cycle: RegWrite=0.
- Both valid for 4 cycles (req0 rd=1 address=0x10 MemtoReg=0; req1 rd=2 read_data=0x20 MemtoReg=1) -> grants 0,1,0,1. Writes alternate reg1=0x10 / reg2=0x20. conflict_cnt=4.
- req1 rd=31 valid -> req1_ready=1, RegWrite stays 0, prio becomes 0.
- Both valid with wb_stall=1 for 3 cycles, then released -> no ready, no RegWrite, conflict_cnt unchanged. First grant after release goes to req0 (prio 0).
- Both valid continuously for 300 cycles -> conflict_cnt=255 and holds.
- Assert reset_n=0 mid-cycle during back-to-back transfers -> RegWrite, WriteRegister, WriteData and conflict_cnt drop to 0 immediately, without waiting for clk. After release, the first dual request grants req0.
